dual_issue_buffer: RTL and testbench
====================================

Name: dual_issue_buffer

Overview:
- Instruction buffer and dual-issue scheduler between fetch and the two decode slots of the superscalar pipeline.
- Fetch pushes up to two instructions per cycle; the block presents the oldest one or two instructions to decode.
- It pairs the second instruction only when the pair is hazard-free within the pair. Cross-stage hazards remain the job of the downstream hazard/forward unit, which stalls this block.

Parameters:
DEPTH, 8, number of entries; power of two, >= 4
PC_W, 64, program counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  discard all entries (branch redirect)
in_valid  in  2  push enables; bit0 = older instruction, bit1 = younger
in_pc0, in_pc1  in  PC_W  PCs of pushed instructions
in_raw0, in_raw1  in  32  raw instruction words
in_ready  out  1  buffer can accept a two-instruction push this cycle
stall  in  1  downstream hold; no pop this cycle
issue_valid  out  2  bit0: slot0 valid; bit1: slot1 valid (pair issued)
issue_pc0, issue_pc1  out  PC_W  PCs of the head and head+1 entries
issue_raw0, issue_raw1  out  32  instruction words of the head and head+1 entries
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Interface: single clock clk. reset is synchronous and active-high.
- Storage and pointers:
  - Circular storage with head and tail pointers of $clog2(DEPTH) bits; both wrap modulo DEPTH.
  - count is the registered occupancy.
- Reset and flush:
  - On reset: head = tail = count = 0. All outputs follow from this: issue_valid = 0, in_ready = 1. issue_pc/raw fields are don't-care when invalid but must not be X in simulation; drive 0.
  - flush has priority over push and pop. The next cycle has an empty buffer and any same-cycle push is dropped.
  - reset has priority over flush.
- Push:
  - in_ready = (DEPTH - count) >= 2. This uses the registered count and ignores any same-cycle pop.
  - Push happens only when in_ready = 1.
  - in_valid = 01 writes in_pc0/raw0 at tail, and tail advances by 1.
  - in_valid = 11 writes entry 0 at tail and entry 1 at tail+1, and tail advances by 2.
  - in_valid = 10 is illegal and ignored: no write.
  - A push while in_ready = 0 is ignored. Fetch must hold.
- Issue outputs:
  - Combinational from the head and head+1 entries and count.
  - issue_valid[0] = (count >= 1).
  - issue_valid[1] = (count >= 2) && pair_ok.
- Pop: on a clock edge with stall = 0 and flush = 0, head advances by popcount(issue_valid) and count updates by pushed − popped. Simultaneous push and pop are allowed.
- Decode fields: opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
- Opcode classes (RV64I):
  - LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, OP 0110011, OP-IMM 0010011, OP-32 0111011, OP-IMM-32 0011011, LUI 0110111, AUIPC 0010111. Any other opcode is class OTHER.
  - writes_rd: all listed classes except STORE and BRANCH, and only when rd != 0.
  - reads_rs1: all listed classes except LUI, AUIPC and JAL.
  - reads_rs2: OP, OP-32, STORE, BRANCH.
  - mem: LOAD, STORE.
  - ctrl: BRANCH, JAL, JALR.
- pair_ok is true only when none of the following holds:
  - slot0 is ctrl.
  - Either slot is OTHER.
  - Both slots are mem.
  - RAW inside the pair: slot0 writes_rd and (slot1 reads_rs1 with rs1 == rd0, or slot1 reads_rs2 with rs2 == rd0).
  - WAW inside the pair: both write rd with rd0 == rd1.
- Boundaries:
  - Empty buffer: issue_valid = 00.
  - Single entry: slot1 is never valid.
  - Pointer wrap across DEPTH-1 → 0 must be seamless for both the write pair and the read pair.
  - Full or nearly full buffer (count >= DEPTH-1): in_ready = 0.
  - While stall = 1: outputs are stable except that pushes may add entries, which can newly enable slot1.

Test Plan:
- Reset, then push 11 with addi x1,x0,1 (raw 0x00100093) and addi x2,x0,2 (raw 0x00200113) -> next cycle count=2, issue_valid=11; with stall=0 the following cycle count=0.
- Push 11 with addi x1,x0,1 and add x3,x1,x1 (RAW on x1) -> issue_valid=01; after pop, slot0=add, issue_valid=01, count=1.
- Push 11 with lw x5,0(x2) and sw x6,4(x2) (both mem) -> issue_valid=01. Push 11 with beq x0,x0,8 and addi -> issue_valid=01 (ctrl in slot0).
- Fill DEPTH=8 with 4 pairs of independent addi under stall=1 -> in_ready=0 once count>=7; the extra push is dropped and count stays 8. Release stall -> pops 2 per cycle, head wraps 7→0 with correct PC order.
- Count=6 with flush=1 and simultaneous push 11 -> next cycle count=0, issue_valid=00, in_ready=1.
- Assert reset mid-stream (count=5, stall=0, push active) -> next cycle count=0, issue_valid=00; in_valid=10 pushed afterwards -> count stays 0.

Source files
------------

// File: rtl/dual_issue_buffer.sv
// dual_issue_buffer
//   Instruction buffer between fetch and the two decode slots. Fetch pushes up
//   to two instructions per cycle into a circular store; the oldest one or two
//   entries are presented to decode. The second entry is offered only when the
//   pair is free of intra-pair hazards and resource conflicts.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   flush                 drop every entry (branch redirect), beats push/pop
//   in_valid[1:0]         push enables (bit0 older, bit1 younger; 10 ignored)
//   in_pc0/1, in_raw0/1   pushed PCs and instruction words
//   in_ready              room for a two-instruction push (registered count)
//   stall                 downstream hold, suppresses pop
//   issue_valid[1:0]      slot0 / slot1 valid
//   issue_pc0/1, issue_raw0/1  head and head+1 entries (zero when not present)
//   count                 registered occupancy

module dual_issue_buffer #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [1:0]               in_valid,
    input  logic [PC_W-1:0]          in_pc0,
    input  logic [PC_W-1:0]          in_pc1,
    input  logic [31:0]              in_raw0,
    input  logic [31:0]              in_raw1,
    output logic                     in_ready,
    input  logic                     stall,
    output logic [1:0]               issue_valid,
    output logic [PC_W-1:0]          issue_pc0,
    output logic [PC_W-1:0]          issue_pc1,
    output logic [31:0]              issue_raw0,
    output logic [31:0]              issue_raw1,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;

    typedef struct packed {
        logic writesRd;
        logic readsRs1;
        logic readsRs2;
        logic isMem;
        logic isCtrl;
        logic isOther;
    } insnInfo_t;

    function automatic insnInfo_t decodeInsn(input logic [6:0] opcode, input logic [4:0] rd);
        insnInfo_t info;
        info = '0;
        case (opcode)
            OPC_LOAD:    begin info.writesRd = 1'b1; info.readsRs1 = 1'b1; info.isMem = 1'b1; end
            OPC_STORE:   begin info.readsRs1 = 1'b1; info.readsRs2 = 1'b1; info.isMem = 1'b1; end
            OPC_BRANCH:  begin info.readsRs1 = 1'b1; info.readsRs2 = 1'b1; info.isCtrl = 1'b1; end
            OPC_JAL:     begin info.writesRd = 1'b1; info.isCtrl = 1'b1; end
            OPC_JALR:    begin info.writesRd = 1'b1; info.readsRs1 = 1'b1; info.isCtrl = 1'b1; end
            OPC_OP,
            OPC_OP32:    begin info.writesRd = 1'b1; info.readsRs1 = 1'b1; info.readsRs2 = 1'b1; end
            OPC_OPIMM,
            OPC_OPIMM32: begin info.writesRd = 1'b1; info.readsRs1 = 1'b1; end
            OPC_LUI,
            OPC_AUIPC:   begin info.writesRd = 1'b1; end
            default:     begin info.isOther = 1'b1; end
        endcase
        // x0 is hardwired; a write to it can never create a hazard.
        if (rd == 5'd0) begin
            info.writesRd = 1'b0;
        end
        return info;
    endfunction

    logic [PC_W-1:0] pcMem  [DEPTH];
    logic [31:0]     rawMem [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] headNext;
    logic [AW-1:0] tailNext;

    logic [1:0] pushCnt;
    logic [1:0] popCnt;
    logic       hasOne;
    logic       hasTwo;
    logic       pairOk;
    logic       rawHazard;
    logic       wawHazard;

    logic [31:0] slot0Raw;
    logic [31:0] slot1Raw;
    insnInfo_t   info0;
    insnInfo_t   info1;

    // Natural AW-bit wrap makes DEPTH-1 -> 0 seamless for both pairs.
    assign headNext = head + AW'(1);
    assign tailNext = tail + AW'(1);

    assign slot0Raw = rawMem[head];
    assign slot1Raw = rawMem[headNext];

    assign hasOne   = (count != '0);
    assign hasTwo   = (count >= CW'(2));
    assign in_ready = (count <= CW'(DEPTH - 2));

    always_comb begin
        info0     = decodeInsn(slot0Raw[6:0], slot0Raw[11:7]);
        info1     = decodeInsn(slot1Raw[6:0], slot1Raw[11:7]);
        rawHazard = info0.writesRd &&
                    ((info1.readsRs1 && (slot1Raw[19:15] == slot0Raw[11:7])) ||
                     (info1.readsRs2 && (slot1Raw[24:20] == slot0Raw[11:7])));
        wawHazard = info0.writesRd && info1.writesRd && (slot0Raw[11:7] == slot1Raw[11:7]);
        pairOk    = !(info0.isCtrl || info0.isOther || info1.isOther ||
                      (info0.isMem && info1.isMem) || rawHazard || wawHazard);
    end

    assign issue_valid = {hasTwo && pairOk, hasOne};
    assign issue_pc0   = hasOne ? pcMem[head]      : '0;
    assign issue_raw0  = hasOne ? slot0Raw         : '0;
    assign issue_pc1   = hasTwo ? pcMem[headNext]  : '0;
    assign issue_raw1  = hasTwo ? slot1Raw         : '0;

    always_comb begin
        pushCnt = 2'd0;
        if (in_ready) begin
            case (in_valid)
                2'b01:   pushCnt = 2'd1;
                2'b11:   pushCnt = 2'd2;
                default: pushCnt = 2'd0;
            endcase
        end
        popCnt = 2'd0;
        if (!stall && !flush) begin
            popCnt = issue_valid[1] ? 2'd2 : {1'b0, issue_valid[0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(popCnt);
            tail  <= tail + AW'(pushCnt);
            count <= count + CW'(pushCnt) - CW'(popCnt);
        end
    end

    // Storage needs no reset: reads are gated by count.
    always_ff @(posedge clk) begin
        if (!reset && !flush && (pushCnt != 2'd0)) begin
            pcMem[tail]  <= in_pc0;
            rawMem[tail] <= in_raw0;
            if (pushCnt == 2'd2) begin
                pcMem[tailNext]  <= in_pc1;
                rawMem[tailNext] <= in_raw1;
            end
        end
    end

endmodule

// File: tb/tb_dual_issue_buffer.sv
module tb_dual_issue_buffer;

    localparam int DEPTH = 8;
    localparam int PC_W  = 64;

    localparam logic [6:0] LD    = 7'b0000011;
    localparam logic [6:0] ST    = 7'b0100011;
    localparam logic [6:0] BR    = 7'b1100011;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPI   = 7'b0010011;
    localparam logic [6:0] OP32  = 7'b0111011;
    localparam logic [6:0] OPI32 = 7'b0011011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] OTH   = 7'b1111111;

    logic            clk;
    logic            reset;
    logic            flush;
    logic [1:0]      in_valid;
    logic [PC_W-1:0] in_pc0;
    logic [PC_W-1:0] in_pc1;
    logic [31:0]     in_raw0;
    logic [31:0]     in_raw1;
    logic            in_ready;
    logic            stall;
    logic [1:0]      issue_valid;
    logic [PC_W-1:0] issue_pc0;
    logic [PC_W-1:0] issue_pc1;
    logic [31:0]     issue_raw0;
    logic [31:0]     issue_raw1;
    logic [3:0]      count;

    int checks = 0;
    int errors = 0;

    dual_issue_buffer #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_pc0(in_pc0), .in_pc1(in_pc1),
        .in_raw0(in_raw0), .in_raw1(in_raw1), .in_ready(in_ready),
        .stall(stall), .issue_valid(issue_valid),
        .issue_pc0(issue_pc0), .issue_pc1(issue_pc1),
        .issue_raw0(issue_raw0), .issue_raw1(issue_raw1), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string      name;
        logic [31:0] raw0;
        logic [31:0] raw1;
        logic [1:0]  expValid;
    } pairVec_t;

    pairVec_t vecs[$];

    // Reference queue contents for the random phase.
    logic [PC_W-1:0] qPc[$];
    logic [31:0]     qRaw[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] v, input logic [63:0] p0, input logic [31:0] r0,
                         input logic [63:0] p1, input logic [31:0] r1);
        in_valid = v;
        in_pc0   = p0;
        in_raw0  = r0;
        in_pc1   = p1;
        in_raw1  = r1;
    endtask

    task automatic idle();
        in_valid = 2'b00;
    endtask

    task automatic doFlush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, op};
    endfunction

    // Pairing rules stated directly on opcode sets.
    function automatic bit modelPair(input logic [31:0] a, input logic [31:0] b);
        logic [6:0] opA = a[6:0];
        logic [6:0] opB = b[6:0];
        logic [4:0] rdA = a[11:7];
        logic [4:0] rdB = b[11:7];
        bit knownA = opA inside {LD, ST, BR, JAL, JALR, OP, OPI, OP32, OPI32, LUI, AUIPC};
        bit knownB = opB inside {LD, ST, BR, JAL, JALR, OP, OPI, OP32, OPI32, LUI, AUIPC};
        bit wA = knownA && !(opA inside {ST, BR}) && (rdA != 5'd0);
        bit wB = knownB && !(opB inside {ST, BR}) && (rdB != 5'd0);
        bit r1B = !(opB inside {LUI, AUIPC, JAL});
        bit r2B = opB inside {OP, OP32, ST, BR};
        if (!knownA || !knownB) return 1'b0;
        if (opA inside {BR, JAL, JALR}) return 1'b0;
        if ((opA inside {LD, ST}) && (opB inside {LD, ST})) return 1'b0;
        if (wA && ((r1B && b[19:15] == rdA) || (r2B && b[24:20] == rdA))) return 1'b0;
        if (wA && wB && rdA == rdB) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [6:0] pickOp(input int i);
        case (i)
            0: return LD;    1: return ST;    2: return BR;    3: return JAL;
            4: return JALR;  5: return OP;    6: return OPI;   7: return OP32;
            8: return OPI32; 9: return LUI;   10: return AUIPC;
            default: return OTH;
        endcase
    endfunction

    function automatic logic [31:0] randInsn();
        logic [31:0] r;
        r = $urandom;
        r[6:0]   = pickOp($urandom_range(0, 12));
        r[11:7]  = 5'($urandom_range(0, 3));
        r[19:15] = 5'($urandom_range(0, 3));
        r[24:20] = 5'($urandom_range(0, 3));
        return r;
    endfunction

    initial begin
        logic [63:0] pcCnt;
        reset = 1'b1;
        flush = 1'b0;
        stall = 1'b0;
        drive(2'b00, 64'd0, 32'd0, 64'd0, 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(issue_valid), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_pc0", issue_pc0, 64'd0);
        check("rst_raw0", 64'(issue_raw0), 64'd0);

        // Independent addi pair issues together and drains in one cycle
        drive(2'b11, 64'h1000, 32'h00100093, 64'h1004, 32'h00200113);
        tick();
        idle();
        check("s1_count", 64'(count), 64'd2);
        check("s1_valid", 64'(issue_valid), 64'd3);
        check("s1_pc0", issue_pc0, 64'h1000);
        check("s1_pc1", issue_pc1, 64'h1004);
        tick();
        check("s1_drain", 64'(count), 64'd0);

        // RAW on x1 -> single issue, then add moves to slot0
        drive(2'b11, 64'h1100, 32'h00100093, 64'h1104, 32'h001081B3);
        tick();
        idle();
        check("s2_valid", 64'(issue_valid), 64'd1);
        tick();
        check("s2_count", 64'(count), 64'd1);
        check("s2_raw0", 64'(issue_raw0), 64'h001081B3);
        check("s2_valid1", 64'(issue_valid), 64'd1);
        tick();
        check("s2_drain", 64'(count), 64'd0);

        // Table of pair classifications (buffer held under stall)
        vecs.push_back('{"indep",      mk(OPI, 1, 0, 0),   mk(OPI, 2, 0, 0),   2'b11});
        vecs.push_back('{"raw_rs1",    mk(OPI, 1, 0, 0),   mk(OP, 3, 1, 2),    2'b01});
        vecs.push_back('{"raw_rs2",    mk(OPI, 1, 0, 0),   mk(OP, 3, 2, 1),    2'b01});
        vecs.push_back('{"rd0_nohaz",  mk(OPI, 0, 0, 0),   mk(OP, 3, 0, 0),    2'b11});
        vecs.push_back('{"waw",        mk(OPI, 1, 0, 0),   mk(OPI, 1, 2, 0),   2'b01});
        vecs.push_back('{"waw_x0",     mk(OPI, 0, 1, 0),   mk(OPI, 0, 2, 0),   2'b11});
        vecs.push_back('{"ld_st",      32'h00012283,       32'h00612223,       2'b01});
        vecs.push_back('{"ld_alu",     mk(LD, 5, 2, 0),    mk(OPI, 6, 2, 0),   2'b11});
        vecs.push_back('{"br_slot0",   32'h00000463,       mk(OPI, 1, 0, 0),   2'b01});
        vecs.push_back('{"br_slot1",   mk(OPI, 1, 0, 0),   mk(BR, 0, 2, 3),    2'b11});
        vecs.push_back('{"oth_slot1",  mk(OPI, 1, 0, 0),   mk(OTH, 2, 0, 0),   2'b01});
        vecs.push_back('{"oth_slot0",  mk(OTH, 1, 0, 0),   mk(OPI, 2, 0, 0),   2'b01});
        vecs.push_back('{"jal_slot0",  mk(JAL, 1, 0, 0),   mk(OPI, 2, 0, 0),   2'b01});
        vecs.push_back('{"lui_raw",    mk(LUI, 1, 0, 0),   mk(OPI, 2, 1, 0),   2'b01});
        vecs.push_back('{"jal_nors1",  mk(OPI, 1, 0, 0),   mk(JAL, 2, 1, 1),   2'b11});
        vecs.push_back('{"lui_nors1",  mk(OPI, 1, 0, 0),   mk(LUI, 2, 1, 1),   2'b11});
        vecs.push_back('{"imm_nors2",  mk(OPI, 1, 0, 0),   mk(OPI, 2, 3, 1),   2'b11});
        vecs.push_back('{"st_rs2",     mk(OPI, 5, 0, 0),   mk(ST, 0, 2, 5),    2'b01});
        vecs.push_back('{"br_rs2",     mk(OPI, 5, 0, 0),   mk(BR, 0, 2, 5),    2'b01});
        vecs.push_back('{"auipc_jal",  mk(AUIPC, 1, 0, 0), mk(JAL, 1, 0, 0),   2'b01});
        vecs.push_back('{"op32_raw",   mk(OPI32, 4, 0, 0), mk(OP32, 6, 3, 4),  2'b01});
        vecs.push_back('{"st_wr_x0",   mk(ST, 0, 1, 2),    mk(OPI, 0, 0, 0),   2'b11});

        stall = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            doFlush();
            drive(2'b11, 64'h4000 + 64'(8 * i), vecs[i].raw0, 64'h4004 + 64'(8 * i), vecs[i].raw1);
            tick();
            idle();
            check({"tbl_", vecs[i].name}, 64'(issue_valid), 64'(vecs[i].expValid));
        end
        doFlush();

        // Fill with head/tail offset by one so both read and write pairs wrap
        drive(2'b01, 64'h2000, mk(OPI, 9, 0, 0), 64'd0, 32'd0);
        tick();
        idle();
        stall = 1'b0;
        tick();
        check("w_pre_count", 64'(count), 64'd0);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("w_ready", 64'(in_ready), 64'd1);
            drive(2'b11, 64'h3000 + 64'(8 * i), mk(OPI, 5'(2 * i + 1), 0, 0),
                  64'h3004 + 64'(8 * i), mk(OPI, 5'(2 * i + 2), 0, 0));
            tick();
        end
        check("w_full_count", 64'(count), 64'd8);
        check("w_full_ready", 64'(in_ready), 64'd0);
        drive(2'b11, 64'hdead, mk(OPI, 10, 0, 0), 64'hbeef, mk(OPI, 11, 0, 0));
        tick();
        idle();
        check("w_drop_count", 64'(count), 64'd8);
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("w_valid", 64'(issue_valid), 64'd3);
            check("w_pc0", issue_pc0, 64'h3000 + 64'(8 * k));
            check("w_pc1", issue_pc1, 64'h3004 + 64'(8 * k));
            tick();
        end
        check("w_empty", 64'(count), 64'd0);

        // count=7 blocks push; count=6 flushed with simultaneous push
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 64'h5000 + 64'(8 * i), mk(OPI, 1, 0, 0), 64'h5004 + 64'(8 * i), mk(OPI, 2, 0, 0));
            tick();
        end
        drive(2'b01, 64'h5100, mk(OPI, 3, 0, 0), 64'd0, 32'd0);
        tick();
        idle();
        check("c7_count", 64'(count), 64'd7);
        check("c7_ready", 64'(in_ready), 64'd0);
        doFlush();
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 64'h6000 + 64'(8 * i), mk(OPI, 1, 0, 0), 64'h6004 + 64'(8 * i), mk(OPI, 2, 0, 0));
            tick();
        end
        check("f_pre_count", 64'(count), 64'd6);
        flush = 1'b1;
        drive(2'b11, 64'h6100, mk(OPI, 1, 0, 0), 64'h6104, mk(OPI, 2, 0, 0));
        tick();
        flush = 1'b0;
        idle();
        check("f_count", 64'(count), 64'd0);
        check("f_valid", 64'(issue_valid), 64'd0);
        check("f_ready", 64'(in_ready), 64'd1);

        // Reset mid-stream with pop and push active; then illegal 10 push
        for (int i = 0; i < 2; i++) begin
            drive(2'b11, 64'h7000 + 64'(8 * i), mk(OPI, 1, 0, 0), 64'h7004 + 64'(8 * i), mk(OPI, 2, 0, 0));
            tick();
        end
        drive(2'b01, 64'h7100, mk(OPI, 3, 0, 0), 64'd0, 32'd0);
        tick();
        check("r_pre_count", 64'(count), 64'd5);
        stall = 1'b0;
        drive(2'b11, 64'h7200, mk(OPI, 4, 0, 0), 64'h7204, mk(OPI, 5, 0, 0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("r_count", 64'(count), 64'd0);
        check("r_valid", 64'(issue_valid), 64'd0);
        drive(2'b10, 64'h7300, mk(OPI, 6, 0, 0), 64'h7304, mk(OPI, 7, 0, 0));
        tick();
        idle();
        check("r_10_count", 64'(count), 64'd0);
        check("r_10_valid", 64'(issue_valid), 64'd0);

        // Random traffic against the queue model
        qPc.delete();
        qRaw.delete();
        pcCnt = 64'h10000;
        for (int cyc = 0; cyc < 600; cyc++) begin
            int  mCount;
            bit  mReady;
            bit  mV0;
            bit  mV1;
            int  nPop;
            int  r;
            logic [1:0] v;
            mCount = qPc.size();
            mReady = (DEPTH - mCount) >= 2;
            mV0    = mCount >= 1;
            mV1    = (mCount >= 2) && modelPair(qRaw[0], qRaw[1]);
            check("rnd_count", 64'(count), 64'(mCount));
            check("rnd_ready", 64'(in_ready), 64'(mReady));
            check("rnd_valid", 64'(issue_valid), 64'({mV1, mV0}));
            if (mV0) begin
                check("rnd_pc0", issue_pc0, qPc[0]);
                check("rnd_raw0", 64'(issue_raw0), 64'(qRaw[0]));
            end
            if (mCount >= 2) begin
                check("rnd_pc1", issue_pc1, qPc[1]);
                check("rnd_raw1", 64'(issue_raw1), 64'(qRaw[1]));
            end

            r = $urandom_range(0, 9);
            v = (r < 2) ? 2'b00 : (r < 4) ? 2'b01 : (r < 9) ? 2'b11 : 2'b10;
            stall = ($urandom_range(0, 9) < 3);
            flush = ($urandom_range(0, 49) == 0);
            drive(v, pcCnt, randInsn(), pcCnt + 64'd4, randInsn());
            pcCnt = pcCnt + 64'd8;

            if (flush) begin
                qPc.delete();
                qRaw.delete();
            end else begin
                nPop = stall ? 0 : (mV1 ? 2 : (mV0 ? 1 : 0));
                for (int p = 0; p < nPop; p++) begin
                    void'(qPc.pop_front());
                    void'(qRaw.pop_front());
                end
                if (mReady && (v == 2'b01 || v == 2'b11)) begin
                    qPc.push_back(in_pc0);
                    qRaw.push_back(in_raw0);
                    if (v == 2'b11) begin
                        qPc.push_back(in_pc1);
                        qRaw.push_back(in_raw1);
                    end
                end
            end
            tick();
        end
        flush = 1'b0;
        stall = 1'b0;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
